imdct_job_arbiter: RTL

IMDCT_JOB_ARBITER -- requirements
Module: imdct_job_arbiter

---
 rtl/imdct_job_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/imdct_job_arbiter.sv
// Two-requester arbiter sharing one IMDCT engine: grant, load, start, run, unload.
// Optional run-phase watchdog with sticky err output: IMDCT_ARB_WATCHDOG_EN.
module imdct_job_arbiter #(
   parameter int TO_W = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic [2:0] cfg0,
   input  logic [2:0] cfg1,
   input  logic [1:0] go,
   input  logic [1:0] rel,
   input  logic       eng_done,
   input  logic       eng_progress,
   output logic [1:0] grant,
   output logic [1:0] ack,
   output logic [1:0] job_done,
   output logic       eng_start,
   output logic       eng_auto,
   output logic       eng_func,
   output logic       eng_tabidx,
`ifdef IMDCT_ARB_WATCHDOG_EN
   output logic       err,
`endif
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      START,
      RUN,
      UNLOAD
   } state_t;

   state_t     state, state_n;
   logic [1:0] grant_n, ack_n, done_n;
   logic       start_n;
   logic [2:0] cfg_n;
   logic       last_owner, last_owner_n;
   logic       own, win;

   // Progress is informational only; the watchdog counts every RUN cycle.
   logic       unused_progress;
   assign unused_progress = eng_progress;

`ifdef IMDCT_ARB_WATCHDOG_EN
   logic [TO_W-1:0] cnt, cnt_n;
   logic            err_n;
   localparam logic [TO_W-1:0] CNT_LAST = {{(TO_W-1){1'b1}}, 1'b0};
`endif

   assign own  = grant[1];
   assign busy = (state != IDLE);
   // Tie goes to whoever did not own the engine last.
   assign win  = (req[0] && (!req[1] || last_owner)) ? 1'b0 : 1'b1;

   always_comb begin
      state_n      = state;
      grant_n      = grant;
      ack_n        = 2'b00;
      done_n       = 2'b00;
      start_n      = 1'b0;
      cfg_n        = {eng_auto, eng_func, eng_tabidx};
      last_owner_n = last_owner;
`ifdef IMDCT_ARB_WATCHDOG_EN
      cnt_n        = cnt;
      err_n        = err;
`endif
      unique case (state)
         IDLE: begin
            if (|req) begin
               state_n = LOAD;
               grant_n = win ? 2'b10 : 2'b01;
               ack_n   = win ? 2'b10 : 2'b01;
               cfg_n   = win ? cfg1 : cfg0;
            end
         end
         LOAD: begin
            if (go[own]) begin
               state_n = START;
               start_n = 1'b1;
            end else if (!req[own]) begin
               state_n = IDLE;
               grant_n = 2'b00;
            end
         end
         START: begin
            state_n = RUN;
`ifdef IMDCT_ARB_WATCHDOG_EN
            cnt_n   = '0;
`endif
         end
         RUN: begin
            if (eng_done) begin
               state_n = UNLOAD;
               done_n  = grant;
            end
`ifdef IMDCT_ARB_WATCHDOG_EN
            else if (cnt == CNT_LAST) begin
               state_n = IDLE;
               grant_n = 2'b00;
               err_n   = 1'b1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
`endif
         end
         UNLOAD: begin
            if (rel[own]) begin
               state_n      = IDLE;
               grant_n      = 2'b00;
               last_owner_n = own;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= 2'b00;
         ack        <= 2'b00;
         job_done   <= 2'b00;
         eng_start  <= 1'b0;
         eng_auto   <= 1'b0;
         eng_func   <= 1'b0;
         eng_tabidx <= 1'b0;
         last_owner <= 1'b1;
`ifdef IMDCT_ARB_WATCHDOG_EN
         cnt        <= '0;
         err        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         grant      <= grant_n;
         ack        <= ack_n;
         job_done   <= done_n;
         eng_start  <= start_n;
         {eng_auto, eng_func, eng_tabidx} <= cfg_n;
         last_owner <= last_owner_n;
`ifdef IMDCT_ARB_WATCHDOG_EN
         cnt        <= cnt_n;
         err        <= err_n;
`endif
      end
   end

endmodule
